nios_ii_i2c_master: RTL and testbench

- Avalon-MM slave I2C master that replaces bit-banged SCL/SDA PIOs for configuring the HDMI transmitter over I2C.
- Nios II software issues byte-level commands: START, WRITE byte, READ byte, STOP.
- The block sequences SCL/SDA with a programmable bit rate and reports busy, done and ACK status.
- Pads are open-drain: an *_oe output of 1 pulls the line low; 0 releases it.

---
 rtl/nios_ii_i2c_master.sv | 169 ++++++++++++++++
 tb/tb_nios_ii_i2c_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/nios_ii_i2c_master.sv
// nios_ii_i2c_master: Avalon-MM I2C master, byte commands START/WRITE/READ/STOP on open-drain pads.
// Latency: command starts on its write edge; each bit takes 4 quarters of DIV+1 clks; readdata is combinational.
// Backpressure: none (zero wait states); CMD bits 0-4 and DIV writes are dropped while BUSY. Option macro: I2C_CLOCK_STRETCH_EN.
module nios_ii_i2c_master #(
  parameter int DIV_DEFAULT = 124,
  parameter int DIV_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        irq
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_WRITE, S_READ, S_STOP} state_t;

  state_t           state_q, st_d, first_st;
  logic [1:0]       phase_q, ph_d;
  logic [3:0]       bit_q, bit_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q;
  logic [7:0]       txdata_q, rxdata_q, shift_q;
  logic             busy_q, done_q, rx_nack_q, irq_en_q, irq_q;
  logic             do_write_q, do_read_q, do_stop_q, ack_out_q;
  logic             scl_oe_q, sda_oe_q;
  logic             wr_en, cmd_wr, accept, tick, stall, fin;
  logic             unused_ok;

  assign wr_en  = chipselect & ~write_n;
  assign cmd_wr = wr_en && (address == 2'd0);
  assign accept = cmd_wr && !busy_q && (writedata[3:0] != 4'd0);
  assign scl_oe = scl_oe_q;
  assign sda_oe = sda_oe_q;
  assign irq    = irq_q;

`ifdef I2C_CLOCK_STRETCH_EN
  assign unused_ok = ^writedata[31:DIV_W];
`else
  assign unused_ok = ^{writedata[31:DIV_W], scl_in};
`endif

  // Pad drive for the phase being entered: {scl_oe, sda_oe}
  function automatic logic [1:0] pads(input state_t st, input logic [1:0] ph,
                                      input logic [3:0] bi, input logic [7:0] tx,
                                      input logic ack_out);
    logic scl, sda;
    scl = (ph == 2'd0) || (ph == 2'd3);
    sda = 1'b0;
    case (st)
      S_START: sda = ph[1];
      S_WRITE: sda = (bi == 4'd8) ? 1'b0 : ~tx[3'd7 - bi[2:0]];
      S_READ:  sda = (bi == 4'd8) ? ~ack_out : 1'b0;
      S_STOP: begin
        scl = (ph == 2'd0);
        sda = (ph == 2'd0) || (ph == 2'd1);
      end
      default: ;
    endcase
    return {scl, sda};
  endfunction

  // Quarter-period tick: reload in idle, optionally frozen while a slave stretches SCL in q1
  always_comb begin
    stall = 1'b0;
`ifdef I2C_CLOCK_STRETCH_EN
    stall = (state_q != S_IDLE) && (phase_q == 2'd1) && !scl_in;
`endif
    tick  = (state_q != S_IDLE) && !stall && (cnt_q == '0);
    if (state_q == S_IDLE || stall || tick) cnt_d = div_q;
    else                                    cnt_d = cnt_q - 1'b1;
  end

  // Sequencing: next phase/bit/state after the current quarter, START -> WRITE|READ -> STOP
  always_comb begin
    st_d  = state_q;
    ph_d  = phase_q + 2'd1;
    bit_d = bit_q;
    if (phase_q == 2'd3) begin
      case (state_q)
        S_START: st_d = do_write_q ? S_WRITE : do_read_q ? S_READ : do_stop_q ? S_STOP : S_IDLE;
        S_WRITE, S_READ: begin
          if (bit_q != 4'd8) bit_d = bit_q + 4'd1;
          else begin
            bit_d = 4'd0;
            st_d  = do_stop_q ? S_STOP : S_IDLE;
          end
        end
        default: st_d = S_IDLE;
      endcase
    end
    fin = (phase_q == 2'd3) && (st_d == S_IDLE);
    if (writedata[0])      first_st = S_START;
    else if (writedata[2]) first_st = S_WRITE;
    else if (writedata[3]) first_st = S_READ;
    else                   first_st = S_STOP;
  end

  // Register file and bus FSM with registered pad outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;  phase_q <= 2'd0;  bit_q <= 4'd0;
      cnt_q <= DIV_DEFAULT[DIV_W-1:0];  div_q <= DIV_DEFAULT[DIV_W-1:0];
      txdata_q <= 8'd0;  rxdata_q <= 8'd0;  shift_q <= 8'd0;
      busy_q <= 1'b0;  done_q <= 1'b0;  rx_nack_q <= 1'b0;  irq_en_q <= 1'b0;  irq_q <= 1'b0;
      do_write_q <= 1'b0;  do_read_q <= 1'b0;  do_stop_q <= 1'b0;  ack_out_q <= 1'b0;
      scl_oe_q <= 1'b0;  sda_oe_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= done_q & irq_en_q;
      if (cmd_wr) irq_en_q <= writedata[5];
      if (wr_en && address == 2'd1) txdata_q <= writedata[7:0];
      if (wr_en && address == 2'd3 && !busy_q) div_q <= writedata[DIV_W-1:0];
      if (accept) begin
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
        do_write_q <= writedata[2];
        do_read_q  <= writedata[3] & ~writedata[2];
        do_stop_q  <= writedata[1];
        ack_out_q  <= writedata[4];
        shift_q    <= txdata_q;
        state_q    <= first_st;
        phase_q    <= 2'd0;
        bit_q      <= 4'd0;
        {scl_oe_q, sda_oe_q} <= pads(first_st, 2'd0, 4'd0, txdata_q, writedata[4]);
      end else if (tick) begin
        // End of q2: SCL is high, sample SDA
        if (phase_q == 2'd2) begin
          if (state_q == S_WRITE && bit_q == 4'd8) rx_nack_q <= sda_in;
          if (state_q == S_READ) begin
            if (bit_q != 4'd8) shift_q  <= {shift_q[6:0], sda_in};
            else               rxdata_q <= shift_q;
          end
        end
        state_q <= st_d;
        phase_q <= ph_d;
        bit_q   <= bit_d;
        if (fin) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          {scl_oe_q, sda_oe_q} <= pads(st_d, ph_d, bit_d, shift_q, ack_out_q);
        end
      end
    end
  end

  // Register readback, unused bits zero
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0] = busy_q;
        readdata[1] = rx_nack_q;
        readdata[2] = done_q;
        readdata[5] = irq_en_q;
      end
      2'd1:    readdata[7:0] = txdata_q;
      2'd2:    readdata[7:0] = rxdata_q;
      default: readdata[DIV_W-1:0] = div_q;
    endcase
  end

endmodule

// File: tb/tb_nios_ii_i2c_master.sv
// tb_nios_ii_i2c_master: directed bench with an I2C slave model and a scoreboard of bus bits.
// Latency: checks transfer durations in clks from the accepting write edge.
// Backpressure: none; the slave model can stretch SCL in bit 3 of a write.
module tb_nios_ii_i2c_master;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        scl_oe, sda_oe, irq;
  wire         scl_line, sda_line;

  // slave model controls (driven by the stimulus block only)
  logic        slv_ack = 1'b0, slv_rd = 1'b0, stretch_arm = 1'b0;
  logic [7:0]  slv_byte = 8'd0;
  // slave model state (driven by the monitor only)
  logic        slv_sda_low = 1'b0, slv_scl_hold = 1'b0, stretch_done = 1'b0;
  logic        scl_p = 1'b1, sda_p = 1'b1, scl_oe_p = 1'b0;
  int          bit_cnt = 0, rel_cnt = 0, hold_cnt = 0, stop_cnt = 0, cyc = 0;
  logic [1:0]  obs_q[$];
  logic [1:0]  exp_q[$];

  int n_pass = 0, n_total = 0;

  assign scl_line = ~(scl_oe | slv_scl_hold);
  assign sda_line = ~(sda_oe | slv_sda_low);

  nios_ii_i2c_master dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .scl_in(scl_line), .sda_in(sda_line), .scl_oe(scl_oe), .sda_oe(sda_oe), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model / bus monitor, evaluated on the falling edge
  always @(negedge clk) begin
    scl_p    <= scl_line;
    sda_p    <= sda_line;
    scl_oe_p <= scl_oe;
    if (scl_line && !scl_p) begin
      obs_q.push_back({sda_oe, sda_line});
      bit_cnt <= (bit_cnt == 8) ? 0 : bit_cnt + 1;
    end
    if (scl_line && scl_p && !sda_line && sda_p) bit_cnt <= 0;
    if (scl_line && scl_p && sda_line && !sda_p) stop_cnt <= stop_cnt + 1;
    if (!scl_line) begin
      if (slv_rd) slv_sda_low <= (bit_cnt < 8) ? ~slv_byte[7 - bit_cnt] : 1'b0;
      else        slv_sda_low <= slv_ack && (bit_cnt == 8);
    end
    if (stretch_arm && !stretch_done && !scl_oe && scl_oe_p) begin
      rel_cnt <= rel_cnt + 1;
      if (rel_cnt == 4) begin
        slv_scl_hold <= 1'b1;
        hold_cnt     <= 1;
        stretch_done <= 1'b1;
      end
    end
    if (slv_scl_hold) begin
      hold_cnt <= hold_cnt + 1;
      if (hold_cnt == 50) slv_scl_hold <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_total++;
    assert (o === e) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, o, e);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wait_idle(input int t0, output int dur);
    int n;
    n = 0;
    address = 2'd0;
    do begin
      @(negedge clk);
      n++;
    end while (readdata[0] === 1'b1 && n < 3000);
    dur = cyc - t0;
  endtask

  task automatic push_byte(input logic [7:0] b, input logic master_drives);
    for (int i = 7; i >= 0; i--) exp_q.push_back({master_drives & ~b[i], b[i]});
  endtask

  task automatic check_bits(input string tag);
    logic [1:0] o;
    chk({tag, "_nrise"}, obs_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 2'bxx;
      chk(tag, {30'd0, o}, {30'd0, exp_q.pop_front()});
    end
    obs_q.delete();
  endtask

  initial begin
    logic [31:0] d;
    int t0, dur, s0, exp_dur;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    rd(2'd0, d); chk("rst_status", d, 32'h0);
    rd(2'd1, d); chk("rst_txdata", d, 32'h0);
    rd(2'd2, d); chk("rst_rxdata", d, 32'h0);
    rd(2'd3, d); chk("rst_div", d, 32'd124);
    chk("rst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // register setup
    wr(2'd3, 32'd3);
    wr(2'd1, 32'h72);
    wr(2'd2, 32'hFF);
    rd(2'd3, d); chk("div_rb", d, 32'd3);
    rd(2'd1, d); chk("tx_rb", d, 32'h72);
    rd(2'd2, d); chk("rx_ro", d, 32'h0);

    // START + WRITE 0x72, slave ACKs
    slv_ack = 1'b1;
    obs_q.delete();
    exp_q.push_back(2'b01);
    push_byte(8'h72, 1'b1);
    exp_q.push_back(2'b00);
    wr(2'd0, 32'h05); t0 = cyc;
    wait_idle(t0, dur);
    chk("wr_dur", dur, 160);
    rd(2'd0, d); chk("wr_status", d, 32'h04);
    check_bits("wr_bit");

    // READ + STOP, master ACKs, slave sends 0xA5
    slv_rd = 1'b1; slv_byte = 8'hA5;
    s0 = stop_cnt;
    push_byte(8'hA5, 1'b0);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    wr(2'd0, 32'h0A); t0 = cyc;
    wait_idle(t0, dur);
    chk("rd_dur", dur, 160);
    rd(2'd2, d); chk("rd_rxdata", d, 32'hA5);
    rd(2'd0, d); chk("rd_status", d, 32'h04);
    chk("rd_stop", stop_cnt - s0, 1);
    chk("rd_scl_rel", {31'd0, scl_oe}, 32'd0);
    chk("rd_sda_rel", {31'd0, sda_oe}, 32'd0);
    check_bits("rd_bit");
    slv_rd = 1'b0;

    // WRITE with no slave, IRQ enabled
    slv_ack = 1'b0;
    wr(2'd0, 32'h25); t0 = cyc;
    wait_idle(t0, dur);
    chk("nack_dur", dur, 160);
    chk("nack_status", readdata, 32'h26);
    chk("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_set", {31'd0, irq}, 32'd1);
    obs_q.delete();

    // CMD and DIV writes during BUSY are ignored (IRQ_EN still follows)
    slv_ack = 1'b1;
    wr(2'd0, 32'h04); t0 = cyc;
    repeat (10) @(negedge clk);
    wr(2'd3, 32'd10);
    wr(2'd0, 32'h0F);
    wait_idle(t0, dur);
    chk("busy_dur", dur, 144);
    rd(2'd0, d); chk("busy_status", d, 32'h04);
    rd(2'd3, d); chk("busy_div", d, 32'd3);
    chk("busy_irq", {31'd0, irq}, 32'd0);
    obs_q.delete();

    // slave stretches SCL 50 clks in bit 3
    slv_ack = 1'b0;
    stretch_arm = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
    exp_dur = 210;
`else
    exp_dur = 160;
`endif
    wr(2'd0, 32'h05); t0 = cyc;
    wait_idle(t0, dur);
    chk("stretch_dur", dur, exp_dur);
    rd(2'd0, d); chk("stretch_status", d, 32'h06);
    stretch_arm = 1'b0;
    obs_q.delete();

    // reset mid-transfer releases the lines
    wr(2'd0, 32'h05);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    rd(2'd0, d); chk("mrst_status", d, 32'h0);
    rd(2'd3, d); chk("mrst_div", d, 32'd124);
    chk("mrst_scl_oe", {31'd0, scl_oe}, 32'd0);
    chk("mrst_sda_oe", {31'd0, sda_oe}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
